// File: rtl/serial_tx.sv
// serial_tx: serial frame transmitter.
// Takes one parallel word through a valid/ready handshake and sends it on a single
// line. A frame is a start bit (0), then DATA_W data bits LSB first, then STOP_BITS
// stop bits (1). The line idles high. Bit timing comes from a clock-enable counter
// (baud_cnt), so no derived clocks are used.
//
// Ports:
//   clk       - single clock; all logic on posedge
//   rst       - synchronous, active-high reset
//   tx_data   - word to send; sampled only on accept
//   tx_valid  - source has a word
//   tx_ready  - block can accept (state == IDLE), combinational from state
//   txd       - serial line, registered
//   busy      - frame in progress, registered
//   state     - FSM state for debug: IDLE=0, START=1, SEND=2, STOP=3
module serial_tx #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Terminal values; every counter stops by equality with these.
  localparam logic [15:0] LAST_BAUD = 16'(CLK_DIV - 1);
  localparam logic [4:0]  LAST_BIT  = 5'(DATA_W - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  state_t            state_reg,    state_next;
  logic              txd_reg,      txd_next;
  logic              busy_reg,     busy_next;
  logic [15:0]       baud_cnt_reg, baud_cnt_next;
  logic [4:0]        bit_cnt_reg,  bit_cnt_next;
  logic              stop_cnt_reg, stop_cnt_next;
  logic [DATA_W-1:0] shreg_reg,    shreg_next;
  logic [DATA_W-1:0] shreg_shift;
  logic              bit_end;

  // With CLK_DIV=1 LAST_BAUD is 0 and the counter never leaves 0, so bit_end
  // stays true and every state lasts one cycle.
  assign bit_end     = (baud_cnt_reg == LAST_BAUD);
  assign shreg_shift = shreg_reg >> 1;

  assign tx_ready = (state_reg == IDLE);
  assign txd      = txd_reg;
  assign busy     = busy_reg;
  assign state    = state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shreg_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      txd_reg      <= txd_next;
      busy_reg     <= busy_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      shreg_reg    <= shreg_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    txd_next      = txd_reg;
    busy_next     = busy_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    shreg_next    = shreg_reg;
    // Every bit_end either ends the bit or changes state, so the counter
    // restarts on both; it also clears on entry to START from IDLE.
    baud_cnt_next = bit_end ? 16'd0 : baud_cnt_reg + 16'd1;

    unique case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        txd_next      = 1'b1;
        busy_next     = 1'b0;
        if (tx_valid) begin
          state_next = START;
          txd_next   = 1'b0;
          busy_next  = 1'b1;
          shreg_next = tx_data;
        end
      end

      START: begin
        if (bit_end) begin
          state_next   = SEND;
          txd_next     = shreg_reg[0];
          bit_cnt_next = '0;
        end
      end

      SEND: begin
        if (bit_end) begin
          if (bit_cnt_reg == LAST_BIT) begin
            state_next    = STOP;
            txd_next      = 1'b1;
            stop_cnt_next = 1'b0;
          end else begin
            // Shift first, then drive the new LSB; bit 0 was already on the line.
            shreg_next   = shreg_shift;
            txd_next     = shreg_shift[0];
            bit_cnt_next = bit_cnt_reg + 5'd1;
          end
        end
      end

      STOP: begin
        txd_next = 1'b1;
        if (bit_end) begin
          if (stop_cnt_reg == LAST_STOP) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next    = IDLE;
        txd_next      = 1'b1;
        busy_next     = 1'b0;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        stop_cnt_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed testbench for serial_tx. Two instances share clk and rst:
//   dut  : CLK_DIV=4, DATA_W=8, STOP_BITS=1
//   dut5 : CLK_DIV=1, DATA_W=8, STOP_BITS=2
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, txd, busy;
  logic [1:0] state;

  logic [7:0] tx_data5 = 8'h00;
  logic       tx_valid5 = 1'b0;
  logic       tx_ready5, txd5, busy5;
  logic [1:0] state5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_tx #(.CLK_DIV(4), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .state(state)
  );

  serial_tx #(.CLK_DIV(1), .DATA_W(8), .STOP_BITS(2)) dut5 (
    .clk(clk), .rst(rst), .tx_data(tx_data5), .tx_valid(tx_valid5),
    .tx_ready(tx_ready5), .txd(txd5), .busy(busy5), .state(state5)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected line level for symbol sym of a frame: start, 8 data LSB first, stops.
  function automatic logic frame_bit(input logic [7:0] d, input int sym);
    if (sym == 0) return 1'b0;
    else if (sym <= 8) return d[sym-1];
    else return 1'b1;
  endfunction

  function automatic logic [1:0] frame_state(input int sym);
    if (sym == 0) return 2'd1;
    else if (sym <= 8) return 2'd2;
    else return 2'd3;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_valid5 = 1'b0;
    tick(); tick();
    total++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset: txd=%b busy=%b ready=%b state=%0d, want 1 0 1 0", txd, busy, tx_ready, state);
    end
    total++;
    if (txd5 !== 1'b1 || busy5 !== 1'b0 || tx_ready5 !== 1'b1 || state5 !== 2'd0) begin
      bad++;
      $display("FAIL reset5: txd=%b busy=%b ready=%b state=%0d, want 1 0 1 0", txd5, busy5, tx_ready5, state5);
    end
    rst = 1'b0;
    tick();
    $display("reset: checked");
  endtask

  task automatic test_frame_a5();
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      total++;
      if (txd !== frame_bit(8'hA5, i / 4)) begin
        bad++;
        $display("FAIL a5_txd cycle %0d: got %b want %b", i, txd, frame_bit(8'hA5, i / 4));
      end
      total++;
      if (tx_ready !== 1'b0 || busy !== 1'b1 || state !== frame_state(i / 4)) begin
        bad++;
        $display("FAIL a5_ctrl cycle %0d: ready=%b busy=%b state=%0d want 0 1 %0d",
                 i, tx_ready, busy, state, frame_state(i / 4));
      end
      tick();
    end
    total++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL a5_end: txd=%b ready=%b busy=%b state=%0d want 1 1 0 0", txd, tx_ready, busy, state);
    end
    $display("frame 0xA5: 40-cycle frame checked");
  endtask

  task automatic test_back_to_back();
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;  // tx_valid stays high throughout
    for (int i = 0; i < 40; i++) begin
      total++;
      if (txd !== frame_bit(8'h00, i / 4) || busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_first cycle %0d: txd=%b busy=%b want %b 1", i, txd, busy, frame_bit(8'h00, i / 4));
      end
      tick();
    end
    total++;
    if (txd !== 1'b1 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: txd=%b ready=%b want 1 1", txd, tx_ready);
    end
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      total++;
      if (txd !== frame_bit(8'hFF, i / 4) || busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_second cycle %0d: txd=%b busy=%b want %b 1", i, txd, busy, frame_bit(8'hFF, i / 4));
      end
      tick();
    end
    total++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: txd=%b ready=%b busy=%b want 1 1 0", txd, tx_ready, busy);
    end
    $display("back-to-back 0x00,0xFF: one idle cycle checked");
  endtask

  task automatic test_ignore_while_busy();
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_data = 8'hC3;
    for (int i = 0; i < 40; i++) begin
      tx_valid = i[0];  // toggles; high during the last stop cycle
      total++;
      if (txd !== frame_bit(8'h3C, i / 4)) begin
        bad++;
        $display("FAIL ignore_txd cycle %0d: got %b want %b", i, txd, frame_bit(8'h3C, i / 4));
      end
      tick();
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
        bad++;
        $display("FAIL ignore_idle cycle %0d: txd=%b busy=%b ready=%b want 1 0 1", i, txd, busy, tx_ready);
      end
      tick();
    end
    $display("frame 0x3C with busy-time tx_valid/tx_data changes checked");
  endtask

  task automatic test_reset_mid_frame();
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    total++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: txd=%b busy=%b want 0 1", txd, busy);
    end
    rst = 1'b1;
    tick();
    total++;
    if (txd !== 1'b1 || busy !== 1'b0 || state !== 2'd0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_abort: txd=%b busy=%b state=%0d ready=%b want 1 0 0 1", txd, busy, state, tx_ready);
    end
    rst = 1'b0;
    tick();
    total++;
    if (txd !== 1'b1 || busy !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL midrst_after: txd=%b busy=%b state=%0d want 1 0 0", txd, busy, state);
    end
    tx_data = 8'h81; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      total++;
      if (txd !== frame_bit(8'h81, i / 4) || busy !== 1'b1) begin
        bad++;
        $display("FAIL midrst_81 cycle %0d: txd=%b busy=%b want %b 1", i, txd, busy, frame_bit(8'h81, i / 4));
      end
      tick();
    end
    total++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_end: txd=%b ready=%b busy=%b want 1 1 0", txd, tx_ready, busy);
    end
    $display("reset mid-frame then 0x81 checked");
  endtask

  task automatic test_clkdiv1_two_stop();
    logic [10:0] exp_seq;
    exp_seq = 11'b110_1011_0100;  // bit i = expected txd in cycle i: 0,0,1,0,1,1,0,1,0,1,1
    tx_data5 = 8'h5A; tx_valid5 = 1'b1;
    tick();
    tx_valid5 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      total++;
      if (txd5 !== exp_seq[i] || busy5 !== 1'b1 || tx_ready5 !== 1'b0) begin
        bad++;
        $display("FAIL div1 cycle %0d: txd=%b busy=%b ready=%b want %b 1 0", i, txd5, busy5, tx_ready5, exp_seq[i]);
      end
      tick();
    end
    total++;
    if (txd5 !== 1'b1 || busy5 !== 1'b0 || tx_ready5 !== 1'b1) begin
      bad++;
      $display("FAIL div1_end: txd=%b busy=%b ready=%b want 1 0 1", txd5, busy5, tx_ready5);
    end
    $display("CLK_DIV=1 STOP_BITS=2 frame 0x5A checked");
  endtask

  // Reference receiver: find the start bit, then sample each symbol mid-bit.
  task automatic test_random_loopback();
    int         errs;
    logic [7:0] word, rx;
    bit         seen;
    errs = 0;
    for (int f = 0; f < 1000; f++) begin
      word = 8'($urandom);
      tx_data = word; tx_valid = 1'b1;
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        tick();
        if (txd === 1'b0) seen = 1'b1;
      end
      tx_valid = 1'b0;
      total++;
      if (!seen) begin
        bad++; errs++;
        $display("FAIL loop_start frame %0d: no start bit within 8 cycles", f);
        continue;
      end
      tick(); tick();
      total++;
      if (txd !== 1'b0) begin
        bad++; errs++;
        $display("FAIL loop_framing_start frame %0d: mid-start txd=%b want 0", f, txd);
      end
      rx = 8'h00;
      for (int b = 0; b < 8; b++) begin
        repeat (4) tick();
        rx[b] = txd;
      end
      repeat (4) tick();
      total++;
      if (txd !== 1'b1) begin
        bad++; errs++;
        $display("FAIL loop_framing_stop frame %0d: mid-stop txd=%b want 1", f, txd);
      end
      total++;
      if (rx !== word) begin
        bad++; errs++;
        $display("FAIL loop_data frame %0d: got %h want %h", f, rx, word);
      end
      seen = 1'b0;
      for (int w = 0; w < 6 && !seen; w++) begin
        tick();
        if (tx_ready === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin
        bad++; errs++;
        $display("FAIL loop_ready frame %0d: tx_ready not back within 6 cycles", f);
      end
    end
    $display("random loopback: 1000 frames, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_frame();
    test_clkdiv1_two_stop();
    test_random_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
